// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory command/response signals
// seen by mem_port_arbiter. The slave view belongs to the arbiter; the
// master view belongs to the environment, which drives both requester ports
// and the memory side.
interface mem_port_arbiter_if;
    // Fetch port
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_flush;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        if_stall;

    // Data port
    logic        d_req;
    logic [63:0] d_addr;
    logic [7:0]  d_w_mask;
    logic [63:0] d_wdata;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        d_stall;

    // Memory side
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [7:0]  mem_we_mask;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rvalid, if_rdata, if_stall,
        input  d_req, d_addr, d_w_mask, d_wdata,
        output d_rvalid, d_rdata, d_stall,
        output mem_req, mem_addr, mem_we_mask, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_rvalid, if_rdata, if_stall,
        output d_req, d_addr, d_w_mask, d_wdata,
        input  d_rvalid, d_rdata, d_stall,
        input  mem_req, mem_addr, mem_we_mask, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: shares one single-outstanding memory port between
// an instruction-fetch requester and a data requester. Data normally wins;
// a streak counter lets a waiting fetch through after MAX_STREAK consecutive
// data grants. A fetch flush lets an in-flight fetch finish on the memory
// side but swallows its response pulse.
module mem_port_arbiter #(
    parameter int MAX_STREAK = 3
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic [63:0]         addr_q,      addr_d;
    logic [7:0]          mask_q,      mask_d;
    logic [63:0]         wdata_q,     wdata_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                drop_q,      drop_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q,  d_rvalid_d;
    logic [63:0]         if_rdata_q,  if_rdata_d;
    logic [63:0]         d_rdata_q,   d_rdata_d;

    logic                fetch_wins;
    logic                flush_hit;
    logic                if_rvalid_w;

    // Next-state, arbitration and response capture for the transaction FSM.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        streak_d    = streak_q;
        drop_d      = drop_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        fetch_wins  = 1'b0;
        flush_hit   = bus.if_flush && (owner_q == OWN_IF) && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (bus.if_req || bus.d_req) begin
                    // Fetch only beats a pending data request once the
                    // streak has reached its limit.
                    fetch_wins = bus.if_req && (!bus.d_req || (streak_q == STREAK_MAX));
                    state_d    = S_ISSUE;
                    if (fetch_wins) begin
                        owner_d  = OWN_IF;
                        addr_d   = bus.if_addr;
                        mask_d   = 8'h00;
                        wdata_d  = 64'h0;
                        streak_d = '0;
                    end else begin
                        owner_d = OWN_D;
                        addr_d  = bus.d_addr;
                        mask_d  = bus.d_w_mask;
                        wdata_d = bus.d_wdata;
                        if (!bus.if_req) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end
                end
            end

            S_ISSUE: begin
                if (flush_hit) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_gnt) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (flush_hit) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_rvalid) begin
                    state_d = S_RESP;
                    if (owner_q == OWN_IF) begin
                        // A flush arriving with the response still kills it.
                        if (!(drop_q || flush_hit)) begin
                            if_rvalid_d = 1'b1;
                            if_rdata_d  = bus.mem_rdata;
                        end
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = (mask_q != 8'h00) ? 64'h0 : bus.mem_rdata;
                    end
                end
            end

            S_RESP: begin
                // No re-grant here: arbitration resumes in the next IDLE cycle.
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= 64'h0;
            mask_q      <= 8'h00;
            wdata_q     <= 64'h0;
            streak_q    <= '0;
            drop_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 64'h0;
            d_rdata_q   <= 64'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // A flush landing in the response cycle itself still suppresses the pulse.
    assign if_rvalid_w     = if_rvalid_q && !bus.if_flush;

    assign bus.if_rvalid   = if_rvalid_w;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.d_rvalid    = d_rvalid_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.if_stall    = bus.if_req && !if_rvalid_w;
    assign bus.d_stall     = bus.d_req && !d_rvalid_q;

    assign bus.mem_req     = (state_q == S_ISSUE);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_we_mask = mask_q;
    assign bus.mem_wdata   = wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_STREAK, default 3: max consecutive data grants while a fetch waits.
REQ-002 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port if_req, input, 1: fetch request; held with if_addr stable until if_rvalid.
REQ-005 SHALL have port if_addr, input, 64: fetch byte address.
REQ-006 SHALL have port if_flush, input, 1: discard any in-flight fetch response.
REQ-007 SHALL have port if_rvalid, output, 1: one-cycle fetch response pulse.
REQ-008 SHALL have port if_rdata, output, 64: fetch data, valid with if_rvalid.
REQ-009 SHALL have port d_req, input, 1: data request; held with d_addr, d_w_mask and d_wdata stable until d_rvalid.
REQ-010 SHALL have port d_addr, input, 64: data byte address.
REQ-011 SHALL have port d_w_mask, input, 8: byte write mask; 0 means load.
REQ-012 SHALL have port d_wdata, input, 64: store data.
REQ-013 SHALL have port d_rvalid, output, 1: one-cycle data response pulse (load data or store ack).
REQ-014 SHALL have port d_rdata, output, 64: load data; 0 for stores.
REQ-015 SHALL have port mem_req, output, 1: memory command valid.
REQ-016 SHALL have ports mem_addr, mem_we_mask and mem_wdata, output, 64/8/64: memory command fields, driven from internal registers.
REQ-017 SHALL have port mem_gnt, input, 1: memory accepted the command this cycle.
REQ-018 SHALL have port mem_rvalid, input, 1: memory response valid.
REQ-019 SHALL have port mem_rdata, input, 64: memory response data.
REQ-020 SHALL have ports if_stall and d_stall, output, 1 each: combinational; if_stall = if_req & ~if_rvalid; d_stall = d_req & ~d_rvalid.

Function
REQ-021 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with one transaction outstanding at most.
REQ-022 In IDLE with any request pending, SHALL on the next edge latch the winner's owner, address, mask and data into registers and enter ISSUE.
REQ-023 Arbitration SHALL be: data wins over fetch, except fetch wins when both request and streak == MAX_STREAK.
REQ-024 The streak counter SHALL increment on a data grant with if_req high, clear on a fetch grant, and clear on a data grant with if_req low; it SHALL saturate at MAX_STREAK.
REQ-025 In ISSUE, mem_req SHALL be 1; mem_gnt SHALL move the FSM to WAIT. mem_req SHALL NOT drop before mem_gnt.
REQ-026 In WAIT, mem_rvalid SHALL capture mem_rdata (or 0 if the mask is nonzero) and move the FSM to RESP; mem_req SHALL be 0.
REQ-027 In RESP, the owner's rvalid SHALL be 1 for exactly one cycle with the captured data, then the FSM SHALL return to IDLE.
REQ-028 Minimum latency from request to rvalid SHALL be 4 cycles: grant, issue with mem_gnt, response, RESP. No re-grant SHALL occur in the RESP cycle.
REQ-029 if_flush asserted while the owner is fetch in ISSUE, WAIT or RESP SHALL set a drop flag. The memory transaction SHALL still complete, and if_rvalid SHALL stay 0 for it. The drop flag SHALL clear on return to IDLE.
REQ-030 if_flush in IDLE, or with data as owner, SHALL have no effect.
REQ-031 mem_gnt outside ISSUE and mem_rvalid outside WAIT SHALL be ignored.
REQ-032 if_rdata and d_rdata SHALL hold their last value when their rvalid is low; the non-owner rvalid SHALL always be 0.

Reset
REQ-033 rst SHALL immediately force IDLE, streak 0, drop flag 0, and mem_req, if_rvalid, d_rvalid, if_rdata, d_rdata, mem_addr, mem_we_mask and mem_wdata all to 0.
REQ-034 Reset mid-transaction SHALL abandon the transaction silently; the arbiter SHALL resume arbitration on the first edge after rst deasserts.

Verification
REQ-035 Fetch path: if_req with if_addr=0x100; mem_gnt in ISSUE; mem_rvalid one cycle later with 0xDEADBEEF -> mem_addr=0x100, mem_we_mask=0; if_rvalid one pulse with if_rdata=0xDEADBEEF, 4 cycles after if_req.
REQ-036 Simultaneous requests: if_req and d_req (load 0x200) rise together -> data served first; fetch granted in the IDLE cycle after d_rvalid.
REQ-037 Starvation guard: if_req and d_req both held continuously, MAX_STREAK=3 -> grant order D, D, D, IF, D.
REQ-038 Fetch flush: if_flush pulsed during WAIT of a fetch -> mem_rvalid consumed, if_rvalid stays 0, FSM back in IDLE 2 cycles after mem_rvalid.
REQ-039 Store: d_w_mask=0xFF, d_wdata=0x1122334455667788, d_addr=0x08 -> mem fields match; d_rvalid pulses with d_rdata=0.
REQ-040 Reset mid-WAIT: rst asserted -> mem_req and both rvalid outputs 0 the same cycle; a late mem_rvalid after reset is ignored.
